// File: rtl/symmetric_fir_sequencer_pkg.sv
// Shared types and helpers for the symmetric FIR operand sequencer.
package polyphase_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        GAP     = 3'd3,
        EMIT    = 3'd4
    } seq_state_t;

    // One MAC operation per symmetric tap pair, plus the center tap when N is odd.
    function automatic int num_ops(input int n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/symmetric_fir_sequencer_tap_line.sv
// N-deep sample delay line (x[0] newest) with mirrored read ports x[k] and x[N-1-k].
module symmetric_tap_line
    import polyphase_pkg::*;
#(
    parameter int W     = 16,
    parameter int N     = 31,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic [W-1:0]     din,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [W-1:0]     rd_near,
    output logic [W-1:0]     rd_far
);

    localparam int TW = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0]  taps_r [N];
    logic [TW-1:0] near_idx_s;
    logic [TW-1:0] far_idx_s;

    assign near_idx_s = TW'(rd_idx);
    assign far_idx_s  = TW'(N - 1) - near_idx_s;
    assign rd_near    = taps_r[near_idx_s];
    assign rd_far     = taps_r[far_idx_s];

    // Shift register storage: newest sample enters at index 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) taps_r[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) taps_r[i] <= '0;
        end else if (shift_en) begin
            taps_r[0] <= din;
            for (int i = 1; i < N; i++) taps_r[i] <= taps_r[i-1];
        end
    end

endmodule

// File: rtl/symmetric_fir_sequencer.sv
// Decimating symmetric FIR front end: collects M samples, then walks the tap pairs through an external MAC.
module symmetric_fir_sequencer
    import polyphase_pkg::*;
#(
    parameter  int SAMPLE_WIDTH = 16,
    parameter  int N            = 31,
    parameter  int M            = 2,
    parameter  int TIMEOUT      = 64,
    localparam int NUM_OPS      = num_ops(N),
    localparam int ADDR_W       = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_data,
    input  logic                    coef_we,
    input  logic [ADDR_W-1:0]       coef_addr,
    input  logic [SAMPLE_WIDTH-1:0] coef_data,
    output logic                    mac_valid_in,
    output logic [SAMPLE_WIDTH-1:0] mac_signal_1,
    output logic [SAMPLE_WIDTH-1:0] mac_signal_2,
    output logic [SAMPLE_WIDTH-1:0] mac_signal_3,
    output logic [SAMPLE_WIDTH-1:0] mac_signal_4,
    input  logic                    mac_valid_out,
    input  logic [SAMPLE_WIDTH-1:0] mac_data_out,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic [SAMPLE_WIDTH-1:0] y_data,
    output logic                    error
);

    localparam int W      = SAMPLE_WIDTH;
    localparam int CNT_W  = (M > 1) ? $clog2(M) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(NUM_OPS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(M - 1);
    localparam bit                ODD_TAPS  = (N % 2) == 1;

    seq_state_t        state_r, state_nx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
    logic [ADDR_W-1:0] k_r, k_nx_s;
    logic [WAIT_W-1:0] wait_r, wait_nx_s;
    logic [W-1:0]      acc_r, acc_nx_s;
    logic              s_ready_r, s_ready_nx_s;
    logic              mac_valid_r, mac_valid_nx_s;
    logic [W-1:0]      op1_r, op2_r, op3_r, op4_r;
    logic [W-1:0]      op1_nx_s, op2_nx_s, op3_nx_s, op4_nx_s;
    logic              y_valid_r, y_valid_nx_s;
    logic [W-1:0]      y_data_r, y_data_nx_s;
    logic              error_r, error_nx_s;
    logic              shift_s, load_s;
    logic [W-1:0]      near_s, far_s;
    logic [W-1:0]      coef_r [NUM_OPS];

    symmetric_tap_line #(
        .W     (W),
        .N     (N),
        .IDX_W (ADDR_W)
    ) u_tap_line (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (1'b0),
        .shift_en (shift_s),
        .din      (s_data),
        .rd_idx   (k_r),
        .rd_near  (near_s),
        .rd_far   (far_s)
    );

    assign s_ready      = s_ready_r;
    assign mac_valid_in = mac_valid_r;
    assign mac_signal_1 = op1_r;
    assign mac_signal_2 = op2_r;
    assign mac_signal_3 = op3_r;
    assign mac_signal_4 = op4_r;
    assign y_valid      = y_valid_r;
    assign y_data       = y_data_r;
    assign error        = error_r;

    // Coefficient file: writable only while collecting samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_OPS; i++) coef_r[i] <= '0;
        end else if ((state_r == COLLECT) && coef_we && (int'(coef_addr) < NUM_OPS)) begin
            coef_r[coef_addr] <= coef_data;
        end
    end

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_nx_s     = state_r;
        cnt_nx_s       = cnt_r;
        k_nx_s         = k_r;
        wait_nx_s      = wait_r;
        acc_nx_s       = acc_r;
        s_ready_nx_s   = s_ready_r;
        mac_valid_nx_s = mac_valid_r;
        op1_nx_s       = op1_r;
        op2_nx_s       = op2_r;
        op3_nx_s       = op3_r;
        op4_nx_s       = op4_r;
        y_valid_nx_s   = y_valid_r;
        y_data_nx_s    = y_data_r;
        error_nx_s     = error_r;
        shift_s        = 1'b0;
        load_s         = 1'b0;

        case (state_r)
            COLLECT: begin
                s_ready_nx_s = 1'b1;
                if (s_valid && s_ready_r) begin
                    shift_s = 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        cnt_nx_s     = '0;
                        k_nx_s       = '0;
                        acc_nx_s     = '0;
                        s_ready_nx_s = 1'b0;
                        state_nx_s   = ISSUE;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            // First entry arrives with valid low (line just shifted); entries from GAP arrive preloaded.
            ISSUE: begin
                if (!mac_valid_r) begin
                    load_s = 1'b1;
                end else begin
                    wait_nx_s  = '0;
                    state_nx_s = WAIT;
                end
            end
            WAIT: begin
                if (mac_valid_out) begin
                    acc_nx_s       = mac_data_out;
                    mac_valid_nx_s = 1'b0;
                    if (k_r == LAST_K) begin
                        y_valid_nx_s = 1'b1;
                        y_data_nx_s  = mac_data_out;
                        state_nx_s   = EMIT;
                    end else begin
                        k_nx_s     = k_r + ADDR_W'(1);
                        state_nx_s = GAP;
                    end
                end else if (wait_r == WAIT_LAST) begin
                    error_nx_s     = 1'b1;
                    mac_valid_nx_s = 1'b0;
                    s_ready_nx_s   = 1'b1;
                    state_nx_s     = COLLECT;
                end else begin
                    wait_nx_s = wait_r + WAIT_W'(1);
                end
            end
            GAP: begin
                load_s     = 1'b1;
                state_nx_s = ISSUE;
            end
            EMIT: begin
                if (y_ready) begin
                    y_valid_nx_s = 1'b0;
                    s_ready_nx_s = 1'b1;
                    state_nx_s   = COLLECT;
                end else begin
                    y_valid_nx_s = 1'b1;
                end
            end
            default: begin
                mac_valid_nx_s = 1'b0;
                y_valid_nx_s   = 1'b0;
                s_ready_nx_s   = 1'b0;
                state_nx_s     = COLLECT;
            end
        endcase

        if (load_s) begin
            mac_valid_nx_s = 1'b1;
            op1_nx_s       = near_s;
            op2_nx_s       = (ODD_TAPS && (k_r == LAST_K)) ? '0 : far_s;
            op3_nx_s       = coef_r[k_r];
            op4_nx_s       = acc_r;
        end else begin
            op1_nx_s = op1_r;
        end
    end

    // State, counter and registered-output update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= COLLECT;
            cnt_r       <= '0;
            k_r         <= '0;
            wait_r      <= '0;
            acc_r       <= '0;
            s_ready_r   <= 1'b0;
            mac_valid_r <= 1'b0;
            op1_r       <= '0;
            op2_r       <= '0;
            op3_r       <= '0;
            op4_r       <= '0;
            y_valid_r   <= 1'b0;
            y_data_r    <= '0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            k_r         <= k_nx_s;
            wait_r      <= wait_nx_s;
            acc_r       <= acc_nx_s;
            s_ready_r   <= s_ready_nx_s;
            mac_valid_r <= mac_valid_nx_s;
            op1_r       <= op1_nx_s;
            op2_r       <= op2_nx_s;
            op3_r       <= op3_nx_s;
            op4_r       <= op4_nx_s;
            y_valid_r   <= y_valid_nx_s;
            y_data_r    <= y_data_nx_s;
            error_r     <= error_nx_s;
        end
    end

endmodule

// File: tb/tb_symmetric_fir_sequencer.sv
// Directed bench for symmetric_fir_sequencer with a 3-cycle behavioural MAC.
module tb_symmetric_fir_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_valid, s_ready;
    logic [15:0] s_data;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic        mac_valid_in;
    logic [15:0] mac_signal_1, mac_signal_2, mac_signal_3, mac_signal_4;
    logic        mac_valid_out;
    logic [15:0] mac_data_out;
    logic        y_valid, y_ready;
    logic [15:0] y_data;
    logic        error;

    int tests = 0;
    int fails = 0;

    logic        mac_en;
    logic [1:0]  mac_st;
    logic [1:0]  mac_cnt;
    logic [15:0] mac_res;

    always #5 clk = ~clk;

    symmetric_fir_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .coef_we       (coef_we),
        .coef_addr     (coef_addr),
        .coef_data     (coef_data),
        .mac_valid_in  (mac_valid_in),
        .mac_signal_1  (mac_signal_1),
        .mac_signal_2  (mac_signal_2),
        .mac_signal_3  (mac_signal_3),
        .mac_signal_4  (mac_signal_4),
        .mac_valid_out (mac_valid_out),
        .mac_data_out  (mac_data_out),
        .y_valid       (y_valid),
        .y_ready       (y_ready),
        .y_data        (y_data),
        .error         (error)
    );

    // MAC: IDLE captures, BUSY counts 3 cycles, DONE waits for valid to drop.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mac_st        <= 2'd0;
            mac_cnt       <= 2'd0;
            mac_res       <= 16'd0;
            mac_valid_out <= 1'b0;
            mac_data_out  <= 16'd0;
        end else begin
            mac_valid_out <= 1'b0;
            case (mac_st)
                2'd0: if (mac_valid_in) begin
                    mac_res <= mac_signal_4 + (mac_signal_1 + mac_signal_2) * mac_signal_3;
                    mac_cnt <= 2'd2;
                    mac_st  <= 2'd1;
                end
                2'd1: if (mac_en) begin
                    if (mac_cnt == 2'd0) begin
                        mac_valid_out <= 1'b1;
                        mac_data_out  <= mac_res;
                        mac_st        <= 2'd2;
                    end else begin
                        mac_cnt <= mac_cnt - 2'd1;
                    end
                end
                2'd2: if (!mac_valid_in) mac_st <= 2'd0;
                default: mac_st <= 2'd0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 300) begin
            tick();
            n++;
        end
        chk("send_accepted", 128'(n < 300), 128'd1);
        tick();
        s_valid = 1'b0;
        s_data  = 16'd0;
    endtask

    task automatic recv(input logic [15:0] e, input string tag);
        int n;
        n = 0;
        y_ready = 1'b1;
        while (!y_valid && n < 1000) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 128'(y_valid), 128'd1);
        chk(tag, 128'(y_data), 128'(e));
        tick();
        y_ready = 1'b0;
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic run_impulse(input string pfx);
        for (int i = 0; i < 16; i++) begin
            int pos;
            logic [15:0] e;
            pos = 2 * i + 1;
            if (i == 15) e = 16'd0;
            else if (pos <= 15) e = 16'(pos + 1);
            else e = 16'(31 - pos);
            send((i == 0) ? 16'd1 : 16'd0);
            send(16'd0);
            recv(e, $sformatf("%s_y%0d", pfx, i));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen_y;
        reset_n   = 1'b0;
        s_valid   = 1'b0;
        s_data    = 16'd0;
        coef_we   = 1'b0;
        coef_addr = 4'd0;
        coef_data = 16'd0;
        y_ready   = 1'b0;
        mac_en    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {s_ready, mac_valid_in, mac_signal_1, mac_signal_2, mac_signal_3,
                              mac_signal_4, y_valid, y_data, error}, 128'd0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("collect_ready", 128'(s_ready), 128'd1);

        // Impulse: h[k] = k+1
        for (int k = 0; k < 16; k++) write_coef(4'(k), 16'(k + 1));
        run_impulse("impulse");

        // DC: h = 1, ones fill the line; output equals count of ones in line
        for (int k = 0; k < 16; k++) write_coef(4'(k), 16'd1);
        for (int j = 0; j < 16; j++) begin
            send(16'd1);
            send(16'd1);
            recv(16'(((2 * j + 2) < 31) ? (2 * j + 2) : 31), $sformatf("dc_y%0d", j));
        end

        // Wrap with backpressure: pairs give 0x10000 -> 0, center gives 0x8000
        for (int k = 0; k < 16; k++) write_coef(4'(k), 16'h8000);
        send(16'd1);
        send(16'd1);
        y_ready = 1'b0;
        n = 0;
        while (!y_valid && n < 1000) begin
            tick();
            n++;
        end
        chk("wrap_valid", 128'(y_valid), 128'd1);
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("backpressure_c%0d", c), {y_valid, y_data, s_ready, mac_valid_in},
                {1'b1, 16'h8000, 1'b0, 1'b0});
            tick();
        end
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        chk("post_emit", {y_valid, s_ready}, {1'b0, 1'b1});

        // Timeout: MAC never answers
        mac_en = 1'b0;
        send(16'd1);
        send(16'd1);
        n = 0;
        seen_y = 1'b0;
        while (!error && n < 200) begin
            tick();
            n++;
            if (y_valid) seen_y = 1'b1;
        end
        chk("timeout_error", 128'(error), 128'd1);
        chk("timeout_window", 128'((n >= 64) && (n <= 70)), 128'd1);
        chk("timeout_no_output", 128'(seen_y), 128'd0);
        chk("timeout_mac_dropped", 128'(mac_valid_in), 128'd0);
        chk("timeout_ready", 128'(s_ready), 128'd1);
        send(16'd5);
        chk("error_sticky", 128'(error), 128'd1);

        // Reset in the middle of WAIT
        send(16'd5);
        repeat (5) tick();
        chk("mid_wait", 128'(mac_valid_in), 128'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {s_ready, mac_valid_in, mac_signal_1, mac_signal_2, mac_signal_3,
                                    mac_signal_4, y_valid, y_data, error}, 128'd0);
        tick();
        tick();
        reset_n = 1'b1;
        mac_en  = 1'b1;
        tick();
        tick();
        chk("post_reset_state", {s_ready, error}, {1'b1, 1'b0});
        for (int k = 0; k < 16; k++) write_coef(4'(k), 16'(k + 1));
        run_impulse("rerun");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
